// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types for the FIFO write-port arbiter.
// Burst lock state lives here so the top and any tooling agree on encoding.
package fifo_write_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } fifo_write_arbiter_state_t;

  function automatic int unsigned index_width(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/round_robin_priority_selector.sv
// Combinational rotating-priority pick: first set request at or after pointer.
// Returns the one-hot selection, its index and whether anything was picked.
module round_robin_priority_selector #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  select,
  output logic [PW-1:0] index,
  output logic          valid
);

  logic [PW-1:0] j;

  always_comb begin
    select = '0;
    index  = '0;
    valid  = 1'b0;
    j      = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(pointer) + k) % N);
      if (!valid && request[j]) begin
        valid     = 1'b1;
        select[j] = 1'b1;
        index     = j;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin merge of several producers onto one FIFO write port.
// Define FIFO_WRITE_ARBITER_BURST_LOCK_EN to hold the grant until request_last.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int REQUESTERS = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [REQUESTERS-1:0]       request,
  input  logic [REQUESTERS*WIDTH-1:0] request_data,
  input  logic [REQUESTERS-1:0]       request_last,
  output logic [REQUESTERS-1:0]       grant,
  output logic                        write_enable,
  output logic [WIDTH-1:0]            write_data,
  input  logic                        full
);

  localparam int PW = index_width(REQUESTERS);
  localparam logic [PW-1:0] LAST = PW'(REQUESTERS - 1);

  logic [PW-1:0]         pointer;
  logic [PW-1:0]         sel_index;
  logic [PW-1:0]         next_pointer;
  logic [REQUESTERS-1:0] sel_onehot;
  logic [REQUESTERS-1:0] eligible;
  logic                  sel_valid;

`ifdef FIFO_WRITE_ARBITER_BURST_LOCK_EN
  fifo_write_arbiter_state_t state;
  logic [PW-1:0]             lock_index;

  // While locked, everyone but the burst owner is invisible, so a
  // dropped request from the owner stalls rather than yielding.
  always_comb begin
    eligible = request;
    if (state == LOCKED)
      eligible = request & (REQUESTERS'(1) << lock_index);
  end
`else
  logic unused_last;

  assign unused_last = ^request_last;
  assign eligible    = request;
`endif

  round_robin_priority_selector #(
    .N  (REQUESTERS),
    .PW (PW)
  ) u_select (
    .request (eligible),
    .pointer (pointer),
    .select  (sel_onehot),
    .index   (sel_index),
    .valid   (sel_valid)
  );

  assign grant = (sel_valid && !full && !reset)
               ? sel_onehot : '0;
  assign write_enable = |grant;
  assign next_pointer = (sel_index == LAST)
                      ? '0 : sel_index + 1'b1;

  always_comb begin
    write_data = '0;
    for (int i = 0; i < REQUESTERS; i++)
      if (grant[i])
        write_data = request_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pointer <= '0;
    else if (write_enable)
      pointer <= next_pointer;
  end

`ifdef FIFO_WRITE_ARBITER_BURST_LOCK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lock_index <= '0;
    end else if (write_enable) begin
      if (state == IDLE && !request_last[sel_index]) begin
        state      <= LOCKED;
        lock_index <= sel_index;
      end else if (state == LOCKED && request_last[sel_index]) begin
        state <= IDLE;
      end
    end
  end
`endif

endmodule
